// File: rtl/serial_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_receiver_pkg
// Constants and FSM encoding shared by the serial receiver and the Serial
// transmitter: 8N1 byte size, idle line level and receiver state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_receiver_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        LINE_IDLE     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/serial_rx_byte.sv
// -----------------------------------------------------------------------------
// serial_rx_byte
// Samples an asynchronous 8N1 line and decodes one byte at a time.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high
//   line      : raw serial line, idle high, asynchronous to clk
//   byte_data : last shifted-in byte (valid while byte_ok is high)
//   byte_ok   : one-cycle pulse, stop bit sampled high
//   byte_err  : one-cycle pulse, stop bit sampled low
//   busy      : high from start detection through the stop-bit sample
// -----------------------------------------------------------------------------
module serial_rx_byte
  import serial_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line,
  output logic [BITS_PER_BYTE-1:0] byte_data,
  output logic                     byte_ok,
  output logic                     byte_err,
  output logic                     busy
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W = $clog2(BITS_PER_BYTE);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_MID  = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_BYTE - 1);

  logic sync1, sync2, rx_prev;
  logic line_fall;

  rx_state_t                state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;

  // sync2 is the first metastability-safe copy of the line; rx_prev delays it
  // once more so a falling edge can be seen in IDLE.
  assign line_fall = rx_prev & ~sync2;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only (synchronous), so it sits
    // inside the clocked block rather than in the sensitivity list.
    if (reset) begin
      sync1     <= LINE_IDLE;
      sync2     <= LINE_IDLE;
      rx_prev   <= LINE_IDLE;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop update from the
      // pre-edge values, which is what makes the 2-flop chain a chain.
      sync1     <= line;
      sync2     <= sync1;
      rx_prev   <= sync2;
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    timer_d   = timer_q + TMR_W'(1);
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte_ok   = 1'b0;
    byte_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (line_fall) state_d = ST_START;
      end

      ST_START: begin
        // Re-check the line half a bit in: a glitch shorter than that is
        // dropped silently.
        if (timer_q == TMR_MID) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = sync2 ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (timer_q == TMR_LAST) begin
          timer_d   = '0;
          shift_d   = {sync2, shift_q[BITS_PER_BYTE-1:1]};  // LSB first
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        // Sampled mid stop bit, so IDLE is reached before a back-to-back
        // start bit can begin.
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          if (sync2) begin
            byte_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            byte_err = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low (break) line must not look like a fresh start bit.
        timer_d = '0;
        if (sync2) state_d = ST_IDLE;
      end

      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign byte_data = shift_q;
  assign busy      = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_STOP);

endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
// Receives 8N1 bytes on SIGNAL and reassembles each group of BYTES bytes
// (first byte in the MSBs) into one word.
//   CLK       : rising-edge clock
//   RESET     : synchronous, active-high
//   SIGNAL    : serial line, idle high, asynchronous to CLK
//   BUFFER    : last complete word, held until the next one
//   VALID     : one-cycle pulse when BUFFER is updated
//   FRAME_ERR : one-cycle pulse on a bad stop bit or an inter-byte gap timeout
//   BUSY      : high while a byte is being received
// -----------------------------------------------------------------------------
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned BYTES        = 5,
  parameter int unsigned GAP_BITS     = 20
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SIGNAL,
  output logic [8*BYTES-1:0]   BUFFER,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int unsigned WORD_W    = 8 * BYTES;
  localparam int unsigned GAP_CYC   = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_CYC + 1);
  localparam int unsigned NB_W      = $clog2(BYTES + 1);

  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYC);
  localparam logic [NB_W-1:0]  NB_FULL   = NB_W'(BYTES);

  logic [BITS_PER_BYTE-1:0] byte_data;
  logic                     byte_ok, byte_err, busy;

  logic [WORD_W-1:0] acc;
  logic [NB_W-1:0]   nbytes;
  logic [GAP_W-1:0]  gap_cnt;
  logic              word_done, gap_hit;

  serial_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (CLK),
    .reset     (RESET),
    .line      (SIGNAL),
    .byte_data (byte_data),
    .byte_ok   (byte_ok),
    .byte_err  (byte_err),
    .busy      (busy)
  );

  assign word_done = (nbytes == NB_FULL);
  // Only armed while a partial word is pending and the line is between bytes.
  assign gap_hit   = !busy && (nbytes != '0) && (gap_cnt == GAP_LIMIT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc       <= '0;
      nbytes    <= '0;
      gap_cnt   <= '0;
      BUFFER    <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;

      // These four events cannot coincide in practice (a byte takes a whole
      // frame, completion lasts one cycle, timeout needs an idle line); the
      // priority only keeps the logic well defined.
      if (byte_err) begin
        FRAME_ERR <= 1'b1;
        acc       <= '0;
        nbytes    <= '0;
      end else if (byte_ok) begin
        acc    <= (acc << BITS_PER_BYTE) | WORD_W'(byte_data);
        nbytes <= nbytes + NB_W'(1);
      end else if (word_done) begin
        // acc is left as is: the next word shifts the old bytes out.
        BUFFER <= acc;
        VALID  <= 1'b1;
        nbytes <= '0;
      end else if (gap_hit) begin
        FRAME_ERR <= 1'b1;
        acc       <= '0;
        nbytes    <= '0;
      end

      // busy rises on every start detection, which restarts the gap window.
      if (busy) begin
        gap_cnt <= '0;
      end else if ((nbytes != '0) && (gap_cnt != GAP_LIMIT)) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  assign BUSY = busy;

endmodule

// File: tb/tb_serial_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_receiver
// Directed plus randomized stimulus for serial_receiver. A byte-level model
// (queue of accepted bytes, list of expected words, expected error count) runs
// alongside the line driver; a negedge monitor records what the DUT reports.
// -----------------------------------------------------------------------------
module tb_serial_receiver;

  localparam int CPB = 16;
  localparam int NB  = 5;
  localparam int GAP = 20;
  localparam int W   = 8 * NB;

  logic         CLK    = 1'b0;
  logic         RESET  = 1'b1;
  logic         SIGNAL = 1'b1;
  logic [W-1:0] BUFFER;
  logic         VALID, FRAME_ERR, BUSY;

  serial_receiver #(
    .CLKS_PER_BIT (CPB),
    .BYTES        (NB),
    .GAP_BITS     (GAP)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SIGNAL    (SIGNAL),
    .BUFFER    (BUFFER),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stop_start = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [W-1:0] got_words[$];
  int           valid_cyc[$];
  int           ferr_cyc[$];
  int           overlap = 0;

  always @(negedge CLK) begin
    if (VALID) begin
      got_words.push_back(BUFFER);
      valid_cyc.push_back(cyc);
    end
    if (FRAME_ERR) ferr_cyc.push_back(cyc);
    if (VALID && FRAME_ERR) overlap++;
  end

  // ---------------- reference model ----------------
  logic [7:0]   pend[$];
  logic [W-1:0] exp_words[$];
  int           exp_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input logic ok);
    logic [W-1:0] w;
    if (!ok) begin
      pend.delete();
      exp_ferr++;
    end else begin
      pend.push_back(b);
      if (pend.size() == NB) begin
        w = '0;
        foreach (pend[i]) w = (w << 8) | W'(pend[i]);
        exp_words.push_back(w);
        pend.delete();
      end
    end
  endtask

  task automatic model_idle(input int bits);
    if (bits >= GAP && pend.size() > 0) begin
      pend.delete();
      exp_ferr++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_scoreboard(input string tag);
    check({tag, "_nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 64'(got_words[i]), 64'(exp_words[i]));
    check({tag, "_nferr"}, 64'(ferr_cyc.size()), 64'(exp_ferr));
    got_words.delete();
    valid_cyc.delete();
    ferr_cyc.delete();
    exp_words.delete();
    exp_ferr = 0;
  endtask

  // ---------------- line driver ----------------
  task automatic bit_period(input logic v);
    SIGNAL = v;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    stop_start = cyc;
    bit_period(stop_ok);
    SIGNAL = 1'b1;
    model_byte(b, stop_ok);
  endtask

  task automatic idle(input int bits);
    for (int i = 0; i < bits; i++) bit_period(1'b1);
    model_idle(bits);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int bad_idx);
    for (int k = 0; k < NB; k++) send_byte(w[8*(NB-1-k) +: 8], k != bad_idx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           d;
    int           frame_end;
    logic [W-1:0] w1, w2;

    // Reset state
    RESET  = 1'b1;
    SIGNAL = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_buffer", 64'(BUFFER), 64'd0);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_ferr", 64'(FRAME_ERR), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Nominal word
    send_word(40'h0102030405, -1);
    d = (valid_cyc.size() > 0) ? valid_cyc[0] - stop_start : -1;
    idle(2);
    check_range("nominal_latency", d, CPB / 2, CPB - 1);
    check("nominal_hold", 64'(BUFFER), 64'h0102030405);
    check_scoreboard("nominal");

    // False start: 5-cycle glitch
    SIGNAL = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("glitch_busy_on", 64'(BUSY), 64'd1);
    SIGNAL = 1'b1;
    repeat (CPB) @(posedge CLK);
    #1;
    check("glitch_busy_off", 64'(BUSY), 64'd0);
    idle(2);
    check_scoreboard("glitch");

    // Bad stop bit on byte 3, then recovery
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(1);
    send_word(40'hAABBCCDDEE, -1);
    idle(2);
    check("badstop_buffer", 64'(BUFFER), 64'hAABBCCDDEE);
    check_scoreboard("badstop");

    // Gap timeout after two bytes
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    frame_end = cyc;
    idle(GAP + 1);
    d = (ferr_cyc.size() > 0) ? ferr_cyc[0] - frame_end : -1;
    check_range("gap_ferr_time", d, (GAP - 1) * CPB, GAP * CPB);
    send_word(40'h1122334455, -1);
    idle(2);
    check_scoreboard("gap");

    // Reset during byte 4
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    RESET  = 1'b1;
    SIGNAL = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    pend.delete();
    check("midrst_buffer", 64'(BUFFER), 64'd0);
    check("midrst_valid", 64'(VALID), 64'd0);
    check("midrst_ferr", 64'(FRAME_ERR), 64'd0);
    check("midrst_busy", 64'(BUSY), 64'd0);
    idle(2);
    check_scoreboard("midrst_quiet");
    send_word(40'hDEADBEEF01, -1);
    idle(2);
    check_scoreboard("midrst_next");

    // Back-to-back words
    w1 = W'({$urandom, $urandom});
    w2 = W'({$urandom, $urandom});
    send_word(w1, -1);
    send_word(w2, -1);
    idle(2);
    d = (valid_cyc.size() > 1) ? valid_cyc[1] - valid_cyc[0] : -1;
    check_range("b2b_spacing", d, 50 * CPB, 50 * CPB);
    check_scoreboard("b2b");

    // Randomized words with short gaps and occasional bad stop bits
    for (int r = 0; r < 6; r++) begin
      int bad;
      w1  = W'({$urandom, $urandom});
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      for (int k = 0; k < NB; k++) begin
        send_byte(w1[8*(NB-1-k) +: 8], k != bad);
        if (k == bad) idle(1);
        else          idle(int'($urandom_range(0, 2)));
      end
    end
    idle(GAP + 1);
    check_scoreboard("random");

    check("valid_ferr_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Downstream counterpart of the `Serial` transmitter. It samples the single-wire `SIGNAL` line, decodes 8N1 bytes, and reassembles each group of five bytes into a 40-bit word. It presents that word on `BUFFER` with a one-cycle `VALID` strobe. Used for loopback verification of the transmitter and as the result-collection port on the receiving board.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be ≥ 4 and even.
- `BYTES`, default 5: bytes per word; `BUFFER` width = 8*`BYTES`.
- `GAP_BITS`, default 20: idle bit periods tolerated between bytes of one word before a partial word is discarded.
- `CLK` in 1: single clock. All logic is rising-edge.
- `RESET` in 1: synchronous, active-high reset.
- `SIGNAL` in 1: serial line. Idle high. Asynchronous to `CLK`.
- `BUFFER` out 8*`BYTES`: last complete word. The first received byte occupies the MSBs.
- `VALID` out 1: one-cycle pulse when `BUFFER` is updated.
- `FRAME_ERR` out 1: one-cycle pulse on a bad stop bit or on a gap timeout.
- `BUSY` out 1: high from start-bit detection through the end of the stop-bit sample.

## Operation
- **Line format:** start bit (0), 8 data bits LSB-first, stop bit (1). Bytes within a word are sent MSB byte first. For example, `40'h0102030405` is sent as 01, 02, 03, 04, 05.
- **Synchronizer:** `SIGNAL` passes through a 2-flop synchronizer. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** a falling edge on the synchronized line moves to START, clears the bit timer, and raises `BUSY`.
  - **START:** at timer = `CLKS_PER_BIT`/2 − 1, sample the line. If low, go to DATA with the timer cleared. If high, it was a false start: return to IDLE, lower `BUSY`, and raise no error.
  - **DATA:** sample every `CLKS_PER_BIT` cycles, shifting right into the byte register. After the 8th sample, go to STOP.
  - **STOP:** sample after `CLKS_PER_BIT` cycles.
    - If high, the byte is accepted: `acc <= {acc, byte}` and `nbytes++`. `BUSY` drops and the FSM returns to IDLE.
    - If low, pulse `FRAME_ERR`, clear `acc` and `nbytes`, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until the synchronized line is high, then go to IDLE. This prevents a break condition from retriggering.
- **Word completion:** when the accepted byte makes `nbytes` = `BYTES`, then on the next cycle `BUFFER` <= assembled word, `VALID` = 1, and `nbytes` is cleared.
- **Gap timeout:** the gap counter runs only in IDLE while `nbytes` > 0 and is cleared on each start-bit detection. When it reaches `GAP_BITS`*`CLKS_PER_BIT`, pulse `FRAME_ERR` and clear `acc` and `nbytes`. `BUFFER` is unchanged.
- `BUFFER` holds its value until the next complete word. No back-pressure exists; a consumer must capture the word on `VALID`.

## Timing
- **Reset values:** `BUFFER` = 0, `VALID` = 0, `FRAME_ERR` = 0, `BUSY` = 0, FSM = IDLE, all counters = 0, synchronizer = 1.
- `RESET` asserted mid-frame aborts immediately. The partial word is lost and `VALID` and `FRAME_ERR` are not pulsed.
- **Detection latency:** start detection occurs 2 cycles after the line edge, due to the synchronizer.
- **Word latency:** `VALID` rises 1 cycle after the stop-bit sample of the last byte, which falls mid stop bit.
- **Back-to-back bytes:** a start bit immediately following a stop bit must be caught. IDLE is reached before the stop bit ends.
- **Simultaneous events:**
  - Word completion and gap timeout are mutually exclusive, because the timeout is disabled while `nbytes` = 0.
  - A `FRAME_ERR` pulse never coincides with `VALID`.
- **Counter widths:**
  - Bit timer: clog2(`CLKS_PER_BIT`).
  - Gap counter: clog2(`GAP_BITS`*`CLKS_PER_BIT`+1), saturating.
  - `nbytes`: clog2(`BYTES`+1).

## Structure
- **Shared package:** FSM state encoding, `BITS_PER_BYTE` = 8, and `LINE_IDLE` = 1'b1. The `Serial` transmitter uses the same constants.
- **Sub-module `serial_rx_byte`:** synchronizer, FSM, and bit timer. It outputs `byte_data`, `byte_ok`, `byte_err`, and `busy`.
- **Top level:** word assembly, `nbytes`, gap counter, and outputs.

## Test plan
- **Nominal word:** drive the bytes of `40'h0102030405` at 16 clocks/bit. Expect `BUFFER` = `40'h0102030405` with exactly one `VALID` pulse, 1 cycle after the 5th stop-bit sample.
- **False start:** apply a 5-cycle low glitch on an idle line. Expect no `BUSY` after the midpoint sample, no `VALID`, and no `FRAME_ERR`.
- **Bad stop bit:** hold the stop bit low on byte 3. Expect a `FRAME_ERR` pulse, no `VALID`, and a recovery in which a following full `40'hAABBCCDDEE` word is received correctly.
- **Gap timeout:** send 2 bytes, then stay idle for 21 bit periods. Expect `FRAME_ERR` at 20 bit periods. A following 5-byte `40'h1122334455` must produce `VALID` with that value.
- **Reset mid-frame:** assert `RESET` for 1 cycle during byte 4. Expect all outputs at their reset values, and the next full word to be received correctly.
- **Back-to-back words:** send two words with no idle gap. Expect two `VALID` pulses exactly 50 bit periods apart, with the correct values.
